// File: rtl/apb_ctrl_pkg.sv
// Shared types and encodings for the APB master sequencer: FSM states,
// CPU op codes and the ERR status codes returned with CPUPREADY.
package apb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_WVERIFY = 8'h04;
  localparam logic [7:0] OP_BCAST   = 8'h05;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_SLVERR = 2'b01;
  localparam logic [1:0] ERR_VERIFY = 2'b10;
  localparam logic [1:0] ERR_BAD    = 2'b11;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ) || (op == OP_WVERIFY) || (op == OP_BCAST);
  endfunction

endpackage

// File: rtl/apb_master_ctrl_watchdog.sv
// ACCESS-phase watchdog: counts stalled cycles, flags the cycle on which the
// count reaches TIMEOUT so the caller can still let a same-cycle PREADY win.
module apb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic CCLK,
  input  logic CPURESET,
  input  logic clr,
  input  logic cnt_en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The current stalled cycle is the TIMEOUT-th one when TIMEOUT-1 already elapsed.
  assign expire = cnt_en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CCLK or posedge CPURESET) begin
    if (CPURESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: captures a CPU command on the rising edge of
// APBMASTERENABLE and runs single, write-verify or broadcast APB transfers.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 21,
  parameter int TIMEOUT    = 16
) (
  input  logic                         CCLK,
  input  logic                         CPURESET,
  input  logic                         CPUPERPHRESET,
  input  logic                         APBMASTERENABLE,
  input  logic [7:0]                   addr,
  input  logic [DATA_W-1:0]            data,
  input  logic [7:0]                   CPUSEL,
  output logic                         CPUPREADY,
  output logic                         INCPURESET,
  output logic [1:0]                   ERR,
  output logic [DATA_W-1:0]            RDATA,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [5:0]                   PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_SLAVES - 1);
  localparam logic [2:0] NS       = 3'(NUM_SLAVES);

  state_t            state_q, state_d;
  logic              en_prev_q;
  logic [7:0]        op_q, op_d;
  logic [5:0]        paddr_q, paddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic              rd_phase_q, rd_phase_d;
  logic              slverr_q, slverr_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              incpu_q, incpu_d;

  logic [DATA_W-1:0] prdata_arr [NUM_SLAVES];
  logic              bus_sel;
  logic              slv_ready;
  logic              slv_err;
  logic [DATA_W-1:0] slv_rdata;
  logic              wd_expire;

  assign bus_sel = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign prdata_arr[gi] = PRDATA[gi*DATA_W +: DATA_W];
    assign PSEL[gi]       = bus_sel && (idx_q == 2'(gi));
  end

  assign slv_ready = PREADY[idx_q];
  assign slv_err   = PSLVERR[idx_q];
  assign slv_rdata = prdata_arr[idx_q];

  apb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CCLK     (CCLK),
    .CPURESET (CPURESET),
    .clr      (state_q == ST_SETUP),
    .cnt_en   ((state_q == ST_ACCESS) && !slv_ready),
    .expire   (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    paddr_d    = paddr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    rd_phase_d = rd_phase_q;
    slverr_d   = slverr_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    incpu_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (APBMASTERENABLE && !en_prev_q) begin
          op_d       = CPUSEL;
          paddr_d    = addr[5:0];
          wdata_d    = data;
          idx_d      = (CPUSEL == OP_BCAST) ? 2'd0 : addr[7:6];
          rd_phase_d = 1'b0;
          slverr_d   = 1'b0;
          rdata_d    = '0;
          if (!op_known(CPUSEL) || ((CPUSEL != OP_BCAST) && ({1'b0, addr[7:6]} >= NS))) begin
            err_d   = ERR_BAD;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A ready slave beats the watchdog even on the expiring cycle.
        if (slv_ready) begin
          slverr_d = slverr_q | slv_err;
          if ((op_q == OP_READ) || rd_phase_q) begin
            rdata_d = slv_rdata;
          end
          if (((op_q == OP_BCAST) && (idx_q != LAST_IDX)) ||
              ((op_q == OP_WVERIFY) && !rd_phase_q)) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_DONE;
            if ((op_q == OP_WVERIFY) && (slv_rdata != wdata_q)) begin
              err_d = ERR_VERIFY;
            end else if (slverr_q || slv_err) begin
              err_d = ERR_SLVERR;
            end else begin
              err_d = ERR_OK;
            end
          end
        end else if (wd_expire) begin
          state_d = ST_IDLE;
          incpu_d = 1'b1;
        end
      end
      ST_NEXT: begin
        if (op_q == OP_BCAST) begin
          idx_d = idx_q + 2'd1;
        end else begin
          rd_phase_d = 1'b1;
        end
        state_d = ST_SETUP;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (CPUPERPHRESET) begin
      state_d    = ST_IDLE;
      op_d       = '0;
      paddr_d    = '0;
      wdata_d    = '0;
      idx_d      = '0;
      rd_phase_d = 1'b0;
      slverr_d   = 1'b0;
      incpu_d    = 1'b0;
    end
  end

  always_ff @(posedge CCLK or posedge CPURESET) begin
    if (CPURESET) begin
      state_q    <= ST_IDLE;
      en_prev_q  <= 1'b0;
      op_q       <= '0;
      paddr_q    <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      rd_phase_q <= 1'b0;
      slverr_q   <= 1'b0;
      err_q      <= '0;
      rdata_q    <= '0;
      incpu_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= APBMASTERENABLE;
      op_q       <= op_d;
      paddr_q    <= paddr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      rd_phase_q <= rd_phase_d;
      slverr_q   <= slverr_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      incpu_q    <= incpu_d;
    end
  end

  assign PENABLE    = (state_q == ST_ACCESS);
  assign PWRITE     = bus_sel && (op_q != OP_READ) && !rd_phase_q;
  assign PADDR      = bus_sel ? paddr_q : '0;
  assign PWDATA     = bus_sel ? wdata_q : '0;
  assign CPUPREADY  = (state_q == ST_DONE);
  assign INCPURESET = incpu_q;
  assign ERR        = err_q;
  assign RDATA      = rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a small APB slave model with
// configurable wait states plus a queue of expected CPU completions.
module tb_apb_master_ctrl;

  localparam int NS = 4;
  localparam int DW = 21;

  logic          CCLK = 1'b0;
  logic          CPURESET;
  logic          CPUPERPHRESET;
  logic          APBMASTERENABLE;
  logic [7:0]    addr;
  logic [DW-1:0] data;
  logic [7:0]    CPUSEL;
  logic          CPUPREADY;
  logic          INCPURESET;
  logic [1:0]    ERR;
  logic [DW-1:0] RDATA;
  logic [NS-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [5:0]    PADDR;
  logic [DW-1:0] PWDATA;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0] PREADY;
  logic [NS-1:0] PSLVERR;

  apb_master_ctrl #(.NUM_SLAVES(NS), .DATA_W(DW), .TIMEOUT(16)) dut (
    .CCLK(CCLK), .CPURESET(CPURESET), .CPUPERPHRESET(CPUPERPHRESET),
    .APBMASTERENABLE(APBMASTERENABLE), .addr(addr), .data(data), .CPUSEL(CPUSEL),
    .CPUPREADY(CPUPREADY), .INCPURESET(INCPURESET), .ERR(ERR), .RDATA(RDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CCLK = ~CCLK;

  // Slave model: every slave answers after wait_cfg stalled ACCESS cycles.
  int            acc_cnt = 0;
  int            wait_cfg = 0;
  logic [NS-1:0] slverr_cfg = '0;
  logic [DW-1:0] slave_rd [NS];

  always @(posedge CCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
  assign PREADY  = (PENABLE && (acc_cnt >= wait_cfg)) ? {NS{1'b1}} : {NS{1'b0}};
  assign PSLVERR = slverr_cfg & PREADY;
  assign PRDATA  = {slave_rd[3], slave_rd[2], slave_rd[1], slave_rd[0]};

  typedef struct packed {
    logic [1:0]    err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  logic [NS-1:0] psel_tr  [64];
  logic          pen_tr   [64];
  logic          pwr_tr   [64];
  logic [5:0]    paddr_tr [64];
  logic [DW-1:0] pwd_tr   [64];
  logic          inc_tr   [64];
  int done_cycle;
  int ready_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] sel, input logic [7:0] a, input logic [DW-1:0] d,
                       input bit push, input logic [1:0] e_err, input logic [DW-1:0] e_rd);
    exp_t e;
    @(negedge CCLK);
    CPUSEL = sel;
    addr   = a;
    data   = d;
    APBMASTERENABLE = 1'b1;
    if (push) begin
      e.err   = e_err;
      e.rdata = e_rd;
      sb.push_back(e);
    end
    $display("[TB] cmd sel=%02h addr=%02h data=%06h expect_done=%0d", sel, a, d, push);
  endtask

  task automatic observe(input int n, input bit drop);
    exp_t e;
    done_cycle  = -1;
    ready_count = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge CCLK);
      psel_tr[k]  = PSEL;
      pen_tr[k]   = PENABLE;
      pwr_tr[k]   = PWRITE;
      paddr_tr[k] = PADDR;
      pwd_tr[k]   = PWDATA;
      inc_tr[k]   = INCPURESET;
      if (CPUPREADY) begin
        ready_count++;
        if (done_cycle < 0) done_cycle = k;
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_ready observed_queue=%0d expected_queue=nonzero", sb.size());
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_err", 64'(ERR), 64'(e.err));
          check("done_rdata", 64'(RDATA), 64'(e.rdata));
        end
      end
    end
    if (drop) APBMASTERENABLE = 1'b0;
  endtask

  initial begin
    int pen_cnt;
    int inc_cnt;
    int inc_cycle;
    logic [NS-1:0] psel_or;
    logic [NS-1:0] bexp;
    CPURESET = 1'b1;
    CPUPERPHRESET = 1'b0;
    APBMASTERENABLE = 1'b0;
    addr = '0;
    data = '0;
    CPUSEL = '0;
    for (int i = 0; i < NS; i++) slave_rd[i] = '0;

    #2;
    check("rst_cpupready", 64'(CPUPREADY), 0);
    check("rst_psel", 64'(PSEL), 0);
    check("rst_err", 64'(ERR), 0);
    check("rst_incpureset", 64'(INCPURESET), 0);
    @(negedge CCLK);
    @(negedge CCLK);
    CPURESET = 1'b0;
    @(negedge CCLK);
    check("post_rst_penable", 64'(PENABLE), 0);
    check("post_rst_rdata", 64'(RDATA), 0);

    // Zero-wait WRITE to slave 1, offset 5.
    wait_cfg = 0;
    issue(8'h01, 8'h45, 21'h1ABCD, 1'b1, 2'b00, '0);
    observe(5, 1'b1);
    check("wr_setup_psel", 64'(psel_tr[1]), 64'(4'b0010));
    check("wr_setup_penable", 64'(pen_tr[1]), 0);
    check("wr_setup_paddr", 64'(paddr_tr[1]), 64'(6'h05));
    check("wr_setup_pwrite", 64'(pwr_tr[1]), 1);
    check("wr_setup_pwdata", 64'(pwd_tr[1]), 64'(21'h1ABCD));
    check("wr_access_penable", 64'(pen_tr[2]), 1);
    check("wr_done_cycle", 64'(done_cycle), 3);
    check("wr_ready_count", 64'(ready_count), 1);

    // READ from slave 3 with three wait states.
    wait_cfg = 3;
    slave_rd[3] = 21'h00777;
    issue(8'h02, 8'hC3, '0, 1'b1, 2'b00, 21'h00777);
    observe(8, 1'b1);
    check("rd_psel", 64'(psel_tr[1]), 64'(4'b1000));
    check("rd_pwrite", 64'(pwr_tr[1]), 0);
    check("rd_access_last", 64'(pen_tr[5]), 1);
    check("rd_done_cycle", 64'(done_cycle), 6);

    // WRITE_VERIFY mismatch on slave 1.
    wait_cfg = 0;
    slave_rd[1] = 21'h00054;
    issue(8'h04, 8'h4A, 21'h00055, 1'b1, 2'b10, 21'h00054);
    observe(8, 1'b1);
    check("wv_first_pwrite", 64'(pwr_tr[1]), 1);
    check("wv_gap_psel", 64'(psel_tr[3]), 0);
    check("wv_second_pwrite", 64'(pwr_tr[4]), 0);
    check("wv_second_psel", 64'(psel_tr[4]), 64'(4'b0010));
    check("wv_done_cycle", 64'(done_cycle), 6);

    // Broadcast with slave 2 flagging PSLVERR.
    slverr_cfg = 4'b0100;
    issue(8'h05, 8'h10, 21'h0F0F0, 1'b1, 2'b01, '0);
    observe(14, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      bexp = (((k - 1) % 3) == 2) ? 4'b0000 : 4'(1 << ((k - 1) / 3));
      check($sformatf("bc_psel_c%0d", k), 64'(psel_tr[k]), 64'(bexp));
    end
    check("bc_done_cycle", 64'(done_cycle), 12);
    slverr_cfg = '0;

    // Ready arriving on the 16th ACCESS cycle is still a success.
    wait_cfg = 15;
    slave_rd[0] = 21'h12345;
    issue(8'h02, 8'h02, '0, 1'b1, 2'b00, 21'h12345);
    observe(22, 1'b1);
    check("edge_done_cycle", 64'(done_cycle), 18);
    inc_cnt = 0;
    for (int k = 1; k <= 22; k++) if (inc_tr[k]) inc_cnt++;
    check("edge_no_incpureset", 64'(inc_cnt), 0);

    // Timeout: slave never ready; enable stays high afterwards.
    wait_cfg = 1000;
    issue(8'h01, 8'h81, 21'h00001, 1'b0, 2'b00, '0);
    observe(26, 1'b1);
    pen_cnt = 0;
    inc_cnt = 0;
    inc_cycle = -1;
    psel_or = '0;
    for (int k = 1; k <= 26; k++) begin
      if (pen_tr[k]) pen_cnt++;
      if (inc_tr[k]) begin
        inc_cnt++;
        if (inc_cycle < 0) inc_cycle = k;
      end
      if (k >= 18) psel_or = psel_or | psel_tr[k];
    end
    check("to_access_cycles", 64'(pen_cnt), 16);
    check("to_incpureset_cycle", 64'(inc_cycle), 18);
    check("to_incpureset_pulses", 64'(inc_cnt), 1);
    check("to_psel_after", 64'(psel_or), 0);
    check("to_no_cpupready", 64'(ready_count), 0);

    // Unknown op code: immediate completion, no bus activity.
    wait_cfg = 0;
    issue(8'h07, 8'h41, 21'h00ABC, 1'b1, 2'b11, '0);
    observe(4, 1'b1);
    check("bad_done_cycle", 64'(done_cycle), 1);
    psel_or = '0;
    for (int k = 1; k <= 4; k++) psel_or = psel_or | psel_tr[k];
    check("bad_no_psel", 64'(psel_or), 0);

    // Abort mid-ACCESS with enable held high.
    wait_cfg = 10;
    issue(8'h02, 8'h41, '0, 1'b0, 2'b00, '0);
    observe(3, 1'b0);
    check("ab_in_access", 64'(pen_tr[3]), 1);
    CPUPERPHRESET = 1'b1;
    @(negedge CCLK);
    CPUPERPHRESET = 1'b0;
    check("ab_psel", 64'(PSEL), 0);
    check("ab_penable", 64'(PENABLE), 0);
    check("ab_pwrite", 64'(PWRITE), 0);
    check("ab_paddr", 64'(PADDR), 0);
    check("ab_pwdata", 64'(PWDATA), 0);
    check("ab_cpupready", 64'(CPUPREADY), 0);
    observe(6, 1'b1);
    psel_or = '0;
    for (int k = 1; k <= 6; k++) psel_or = psel_or | psel_tr[k];
    check("ab_no_retrigger", 64'(psel_or), 0);
    check("ab_no_ready", 64'(ready_count), 0);

    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB master sequencer between the CPU command interface and up to NUM_SLAVES peripherals.
- Captures each CPU command (APBMASTERENABLE, addr, data, CPUSEL) and runs the APB SETUP/ACCESS protocol for it.
- Supports single write, single read, write-verify and broadcast write.
- Returns a one-cycle CPUPREADY completion pulse; a bus timeout forces a CPU reset through INCPURESET.

Parameters:
- NUM_SLAVES, 4: peripheral count. Slave index is addr[7:6], so NUM_SLAVES is at most 4.
- DATA_W, 21: command data and APB data width.
- TIMEOUT, 16: maximum ACCESS cycles allowed without PREADY.

Ports:
- CCLK  in  1  clock
- CPURESET  in  1  reset, asynchronous, active-high
- CPUPERPHRESET  in  1  synchronous abort/clear from CPU
- APBMASTERENABLE  in  1  command valid, held high by CPU until it sees ready
- addr  in  8  [7:6] slave index, [5:0] register offset
- data  in  DATA_W  write data
- CPUSEL  in  8  op code
- CPUPREADY  out  1  one-cycle command-complete pulse
- INCPURESET  out  1  one-cycle pulse requesting CPU reset
- ERR  out  2  status of last command, valid with CPUPREADY
- RDATA  out  DATA_W  read result, valid with CPUPREADY
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  6  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (CPURESET): all outputs 0, state IDLE, edge-detect register 0, watchdog 0.
- Command capture:
  - Only on a rising edge of APBMASTERENABLE (registered previous value) while in IDLE.
  - addr, data and CPUSEL are latched on that edge.
  - A level held high after completion does not retrigger.
- Op codes:
  - 8'h01 WRITE.
  - 8'h02 READ.
  - 8'h04 WRITE_VERIFY: write, then read back the same slave/offset.
  - 8'h05 BCAST: write the same offset/data to slaves 0..NUM_SLAVES-1 in order.
  - Any other code: no bus activity, go to DONE with ERR=2'b11.
- Slave index >= NUM_SLAVES on WRITE/READ/WRITE_VERIFY: no bus activity, ERR=2'b11.
- States: IDLE, SETUP, ACCESS, NEXT, DONE.
  - IDLE -> SETUP on a valid capture.
  - SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA driven; one cycle, then -> ACCESS.
  - ACCESS: PENABLE=1, addresses held stable.
    - On PREADY[idx]: sample PRDATA slice and PSLVERR[idx].
    - Then go to NEXT if more transfers remain, else DONE.
  - NEXT: PSEL=0, PENABLE=0 for one cycle.
    - BCAST: increment idx, then -> SETUP.
    - WRITE_VERIFY: switch to read phase, then -> SETUP.
  - DONE: CPUPREADY=1 for exactly one cycle, ERR/RDATA valid; -> IDLE.
- Latency, zero-wait slave, command edge sampled at edge E:
  - SETUP in cycle E+1, ACCESS in E+2, CPUPREADY in E+3.
  - Each PREADY wait cycle adds 1.
  - BCAST with 4 slaves and no waits: CPUPREADY at E+12.
- ERR priority, highest first:
  - 2'b11 bad op/index.
  - 2'b10 verify mismatch (readback != latched data).
  - 2'b01 any PSLVERR seen during the command (sticky across BCAST and verify phases).
  - 2'b00 ok.
- RDATA: read/readback value; 0 for WRITE and BCAST.
- Watchdog:
  - Counts ACCESS cycles without PREADY[idx].
  - Counter clears in SETUP.
  - On reaching TIMEOUT, with PREADY still low:
    - PSEL and PENABLE drop next cycle.
    - INCPURESET pulses one cycle.
    - No CPUPREADY is issued; state returns to IDLE.
- CPUPERPHRESET high in any state:
  - Next cycle: state IDLE, all APB outputs 0, no CPUPREADY.
  - Captured command is discarded.
  - Edge register is loaded with the current APBMASTERENABLE value.
- Simultaneous events:
  - CPUPERPHRESET beats timeout and PREADY.
  - PREADY on the same cycle the count reaches TIMEOUT counts as success.

Decomposition:
- Package apb_ctrl_pkg holds:
  - state enum;
  - op code localparams OP_WRITE/OP_READ/OP_WVERIFY/OP_BCAST;
  - ERR code localparams.
- One sub-module, apb_watchdog: TIMEOUT-parameterised counter with clear, count-enable and expire output.

Test Plan:
- Zero-wait WRITE: CPUSEL=01, addr=8'h45, data=21'h1ABCD, PREADY all 1 -> PSEL=4'b0010, PADDR=6'h05, PWRITE=1 SETUP at E+1, PENABLE at E+2, CPUPREADY at E+3, ERR=0.
- READ with 3 wait cycles: CPUSEL=02, addr=8'hC3, PRDATA slice3=21'h00777 -> ACCESS lasts 4 cycles, CPUPREADY at E+6, RDATA=21'h00777.
- WRITE_VERIFY mismatch: data=21'h00055, slave returns 21'h00054 -> two transfers (PWRITE 1 then 0), ERR=2'b10.
- BCAST, 4 slaves, PSLVERR[2]=1 -> PSEL walks 0001, 0010, 0100, 1000 with an idle cycle between each; CPUPREADY at E+12, ERR=2'b01.
- Timeout: PREADY held 0, TIMEOUT=16 -> 16 ACCESS cycles, INCPURESET one-cycle pulse, PSEL=0, no CPUPREADY; enable held high gives no retrigger.
- CPUSEL=8'h07, and CPUPERPHRESET asserted mid-ACCESS -> bad op gives CPUPREADY with ERR=2'b11 and no PSEL; the abort gives IDLE next cycle, all APB outputs 0.
